// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter unit.
//
// Contents:
//   PC_OP_*    3-bit encodings of the operation decoded on each rising edge.
//   ras_ptr_w  width of the return-address-stack top pointer, log2(depth).
package pc_pkg;

    localparam logic [2:0] PC_OP_HOLD   = 3'd0;
    localparam logic [2:0] PC_OP_TAIL   = 3'd1;
    localparam logic [2:0] PC_OP_RET    = 3'd2;
    localparam logic [2:0] PC_OP_CALL   = 3'd3;
    localparam logic [2:0] PC_OP_BRANCH = 3'd4;
    localparam logic [2:0] PC_OP_SEQ    = 3'd5;

    // Depth is a power of two >= 2, so this is exactly log2(depth).
    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras -- circular return-address stack.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset (pointer/count only)
//   push            write wr_data above the top; when full the oldest entry is
//                   overwritten and the count saturates at DEPTH
//   pop             drop the top entry (no effect when empty)
//   replace         overwrite the top entry with wr_data
//   wr_data         data for push/replace
//   top_data        current top entry
//   empty, full     count == 0, count == DEPTH
// At most one of push/pop/replace is expected per cycle; push has priority.
module pc_ras
    import pc_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [SIZE-1:0] wr_data,
    output logic [SIZE-1:0] top_data,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  mem_q [DEPTH];
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign top_data = mem_q[ptr_q];

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push) begin
            // Pointer wraps naturally; on a full stack the new top lands on
            // the oldest slot, which is the circular overwrite.
            ptr_d  = ptr_q + 1'b1;
            wr_en  = 1'b1;
            wr_idx = ptr_d;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (replace) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit with stall, branch, call/return via a
// circular return-address stack, and a configurable reset vector.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   stall             hold all state this cycle (controls ignored)
//   branch            load branch_target (ignored when call or ret is high)
//   call              push pc+STEP, load branch_target
//   ret               pop return address into pc
//   branch_target     target for branch/call
//   pc                registered current PC
//   pc_plus           pc+STEP, combinational
//   ras_empty/full    stack occupancy
//   ras_overflow      sticky: push while full
//   ras_underflow     sticky: pop while empty
//   retire_cnt        (only with PC_RETIRE_CNT_EN) count of non-hold edges
//
// Optional feature macro: PC_RETIRE_CNT_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              SIZE      = 32,
    parameter int              STEP      = 1,
    parameter int              RAS_DEPTH = 8,
    parameter logic [SIZE-1:0] RESET_PC  = {SIZE{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch,
    input  logic            call,
    input  logic            ret,
    input  logic [SIZE-1:0] branch_target,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
`ifdef PC_RETIRE_CNT_EN
    output logic [31:0]     retire_cnt,
`endif
    output logic            ras_underflow
);

    logic [SIZE-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [2:0]      op;
    logic            ras_push, ras_pop, ras_replace;
    logic [SIZE-1:0] ras_top;

    assign pc            = pc_q;
    assign pc_plus       = pc_q + SIZE'(STEP);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    pc_ras #(
        .SIZE  (SIZE),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .replace  (ras_replace),
        .wr_data  (pc_plus),
        .top_data (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

    // Priority decode: first match wins.
    always_comb begin
        op = PC_OP_SEQ;
        if (stall) begin
            op = PC_OP_HOLD;
        end else if (call && ret) begin
            op = PC_OP_TAIL;
        end else if (ret) begin
            op = PC_OP_RET;
        end else if (call) begin
            op = PC_OP_CALL;
        end else if (branch) begin
            op = PC_OP_BRANCH;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        case (op)
            PC_OP_HOLD: begin
            end
            PC_OP_TAIL: begin
                // Tail call reuses the caller's slot; an empty stack gets a
                // fresh entry instead. Flags are untouched either way.
                pc_d = branch_target;
                if (ras_empty) begin
                    ras_push = 1'b1;
                end else begin
                    ras_replace = 1'b1;
                end
            end
            PC_OP_RET: begin
                if (!ras_empty) begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end else begin
                    pc_d  = pc_plus;
                    unf_d = 1'b1;
                end
            end
            PC_OP_CALL: begin
                pc_d     = branch_target;
                ras_push = 1'b1;
                if (ras_full) begin
                    ovf_d = 1'b1;
                end
            end
            PC_OP_BRANCH: begin
                pc_d = branch_target;
            end
            default: begin
                pc_d = pc_plus;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    assign retire_cnt = retire_cnt_q;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (op != PC_OP_HOLD) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed bench for pc_unit with default parameters
// (SIZE=32, STEP=1, RAS_DEPTH=8, RESET_PC=all-ones).
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        call;
    logic        ret;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;
`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .call          (call),
        .ret           (ret),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
`ifdef PC_RETIRE_CNT_EN
        .retire_cnt    (retire_cnt),
`endif
        .ras_underflow (ras_underflow)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one set of controls across a rising edge, then sample 1 ns later.
    task automatic step(input logic s, input logic b, input logic c, input logic r,
                        input logic [31:0] tgt);
        stall         = s;
        branch        = b;
        call          = c;
        ret           = r;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any edge.
    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'hFFFF_FFFF);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        branch_target = '0;
        #2;
        check("rst_pc",        pc,                    32'hFFFF_FFFF);
        check("rst_pc_plus",   pc_plus,               32'h0);
        check("rst_empty",     {31'b0, ras_empty},    32'd1);
        check("rst_full",      {31'b0, ras_full},     32'd0);
        check("rst_ovf",       {31'b0, ras_overflow}, 32'd0);
        check("rst_unf",       {31'b0, ras_underflow},32'd0);
        #1 reset = 1'b0;

        // Sequence from reset vector
        seq(); check("seq0", pc, 32'h0);
        seq(); check("seq1", pc, 32'h1);
        seq(); check("seq2", pc, 32'h2);

        // Reset mid-run at pc=0x40
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h40); check("br_40", pc, 32'h40);
        reset_pulse();
        seq(); check("rseq0", pc, 32'h0);
        seq(); check("rseq1", pc, 32'h1);
        seq(); check("rseq2", pc, 32'h2);

        // Branch and stall
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h100); check("br_100", pc, 32'h100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200); check("stall_a", pc, 32'h100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200); check("stall_b", pc, 32'h100);
        seq(); check("post_stall", pc, 32'h101);

        // Stalled call is ignored, not queued
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h300);
        check("stall_call_pc",    pc,                 32'h101);
        check("stall_call_empty", {31'b0, ras_empty}, 32'd1);

        // Call / return
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10); check("br_10", pc, 32'h10);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
        check("call_pc",    pc,                 32'h80);
        check("call_empty", {31'b0, ras_empty}, 32'd0);
        for (int i = 0; i < 4; i++) seq();
        check("call_seq4", pc, 32'h84);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ret_pc",    pc,                 32'h11);
        check("ret_empty", {31'b0, ras_empty}, 32'd1);

        // Overflow: 9 nested calls from pc=0..8 push 1..9 (1 is overwritten)
        reset_pulse();
        seq(); check("ovf_start", pc, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'(i + 1));
        check("full8_full", {31'b0, ras_full},     32'd1);
        check("full8_ovf",  {31'b0, ras_overflow}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h9);
        check("call9_pc",   pc,                    32'h9);
        check("call9_full", {31'b0, ras_full},     32'd1);
        check("call9_ovf",  {31'b0, ras_overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            check($sformatf("ovf_ret%0d", i), pc, 32'(9 - i));
        end
        check("ovf_empty",  {31'b0, ras_empty},     32'd1);
        check("ovf_unf0",   {31'b0, ras_underflow}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("unf_pc",     pc,                     32'h3);
        check("unf_flag",   {31'b0, ras_underflow}, 32'd1);
        check("ovf_sticky", {31'b0, ras_overflow},  32'd1);
        seq();
        check("unf_sticky", {31'b0, ras_underflow}, 32'd1);

        // Tail call with one entry, then tail call on an empty stack
        reset_pulse();
        check("tail_rst_ovf", {31'b0, ras_overflow}, 32'd0);
        seq();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h20); check("br_20", pc, 32'h20);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
        for (int i = 0; i < 16; i++) seq();
        check("tail_at_50", pc, 32'h50);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h90);
        check("tail_pc",    pc,                 32'h90);
        check("tail_empty", {31'b0, ras_empty}, 32'd0);
        check("tail_full",  {31'b0, ras_full},  32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("tail_ret",       pc,                 32'h51);
        check("tail_ret_empty", {31'b0, ras_empty}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hA0);
        check("tail0_pc",    pc,                 32'hA0);
        check("tail0_empty", {31'b0, ras_empty}, 32'd0);
        check("tail0_unf",   {31'b0, ras_underflow}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("tail0_ret", pc, 32'h52);

        // Wrap and priority
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        check("wrap_pc_plus", pc_plus, 32'h0);
        seq(); check("wrap_pc", pc, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h300); check("prio_call", pc, 32'h300);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
        check("prio_ret_wins", pc, 32'h1);
        check("prio_empty",    {31'b0, ras_empty}, 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h700);
        check("prio_call_over_br", pc, 32'h700);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("prio_call_ret", pc, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, the successor to the basic PC register.
- Generates the fetch address each cycle: sequential increment by STEP, branch load, and call/return through an internal circular return-address stack (RAS).
- Adds stall and a configurable reset vector.
- Sits between the branch-resolution logic and instruction-memory address input.

Parameters:
- SIZE, 32, PC width in bits.
- STEP, 1, sequential increment (word-addressed memory uses 1).
- RAS_DEPTH, 8, return-stack entries; power of two, at least 2.
- RESET_PC, {SIZE{1'b1}}, reset value. The default all-ones makes the first fetched address after reset 0.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- stall, in, 1: hold all state this cycle.
- branch, in, 1: load branch_target.
- call, in, 1: push return address, load branch_target.
- ret, in, 1: pop return address into pc.
- branch_target, in, SIZE: target for branch/call.
- pc, out, SIZE: current PC, registered.
- pc_plus, out, SIZE: pc+STEP, combinational.
- ras_empty, out, 1: RAS count == 0.
- ras_full, out, 1: RAS count == RAS_DEPTH.
- ras_overflow, out, 1: sticky; a push occurred while full.
- ras_underflow, out, 1: sticky; a pop occurred while empty.

Behaviour:
Reset
- reset asserted → immediately (asynchronously): pc=RESET_PC, RAS count=0, top pointer=0, ras_overflow=0, ras_underflow=0.
- Consequently ras_empty=1 and ras_full=0.
- RAS entry contents are don't-care after reset.
- reset overrides any other input in the same cycle.
- Release is clean; the first rising edge after release applies normal rules.

Operation decode, evaluated per rising edge, first match wins:
- HOLD, stall=1: nothing changes; call/ret/branch are ignored, not queued.
- TAIL, call=1 and ret=1:
  - pc ← branch_target.
  - If count>0: top entry ← pc+STEP, count unchanged.
  - If count==0: push pc+STEP, count becomes 1.
  - No flags change.
- RET, ret=1:
  - If count>0: pc ← top entry; pointer and count decrement.
  - If count==0: pc ← pc+STEP and ras_underflow ← 1.
- CALL, call=1:
  - Push pc+STEP and set pc ← branch_target.
  - If count==RAS_DEPTH: the oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_overflow ← 1.
- BRANCH, branch=1: pc ← branch_target. branch is ignored whenever call or ret is high.
- SEQ, otherwise: pc ← pc+STEP.

Arithmetic
- All PC arithmetic is modulo 2^SIZE.
- pc = all-ones with STEP=1 wraps to 0. This is not an error.

Timing
- Latency is one cycle from control inputs to pc.
- Push/pop take effect on the same edge as the pc update.
- A ret on the cycle after a call returns that call's pc+STEP.

Flags
- ras_overflow and ras_underflow are cleared only by reset.

Optional Feature:
- Macro: PC_RETIRE_CNT_EN.
- With the macro defined, the block adds:
  - Output retire_cnt, 32 bits.
  - Reset value 0.
  - Increments by 1 on every non-HOLD edge, wrapping at 2^32.
- Without the macro, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg:
  - Localparam encodings for the decoded operation: PC_OP_HOLD, PC_OP_TAIL, PC_OP_RET, PC_OP_CALL, PC_OP_BRANCH, PC_OP_SEQ (3-bit).
  - Helper constant for the log2(RAS_DEPTH) pointer width.
- Natural sub-module: pc_ras.
  - Circular stack holding storage, top pointer and count.
  - Push/pop/replace inputs; top, empty and full outputs.
- pc_unit holds the decode, the pc register, flags and the optional counter.

Test Plan:
- Reset/sequence: assert reset mid-run with pc=0x40 → pc=0xFFFFFFFF immediately, without a clock; after release, 3 edges → pc=0,1,2.
- Branch and stall:
  - branch=1, target=0x100 → pc=0x100.
  - Then stall=1 with branch=1, target=0x200, for 2 cycles → pc stays 0x100.
  - Then release → pc=0x101.
- Call/return:
  - At pc=0x10, call with target=0x80 → pc=0x80, ras_empty=0.
  - Then 4 SEQ edges.
  - Then ret → pc=0x11, ras_empty=1.
- Overflow, RAS_DEPTH=8:
  - 9 nested calls from pc=0,1,...,8.
  - Result: ras_full=1, ras_overflow=1.
  - 8 rets return 9,8,...,2.
  - A 9th ret → pc increments, ras_underflow=1.
- Tail call:
  - After a call from pc=0x20, at pc=0x50 assert call+ret with target=0x90 → pc=0x90, count stays 1.
  - Then ret → pc=0x51.
- Wrap/priority:
  - pc=0xFFFFFFFF SEQ → pc=0.
  - branch+ret with a non-empty RAS → ret wins, branch_target ignored.
